// File: rtl/seq_detect_pkg.sv
// Shared helpers for the serial pattern detector.
// Both functions are evaluated at elaboration to build the transition table.
package seq_detect_pkg;

  localparam int MAX_LEN = 16;

  // Longest prefix of pattern that is a suffix of (prefix_p ++ b).
  // A result equal to len means the pattern just completed.
  function automatic int next_prefix(
    logic [15:0] pattern,
    int          len,
    int          p,
    logic        b
  );
    logic [16:0] s;
    int          res;
    logic        ok;
    s   = '0;
    res = 0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < p) s[5'(i)] = pattern[4'(len - 1 - i)];
    end
    s[5'(p)] = b;
    for (int k = 1; k <= MAX_LEN; k++) begin
      if (k <= p + 1 && k <= len) begin
        ok = 1'b1;
        for (int j = 0; j < MAX_LEN; j++) begin
          if (j < k) begin
            if (s[5'(p + 1 - k + j)] != pattern[4'(len - 1 - j)])
              ok = 1'b0;
          end
        end
        if (ok) res = k;
      end
    end
    return res;
  endfunction

  // Longest proper border: prefix that is also a suffix.
  function automatic int border_len(
    logic [15:0] pattern,
    int          len
  );
    int   res;
    logic ok;
    res = 0;
    for (int k = 1; k < MAX_LEN; k++) begin
      if (k < len) begin
        ok = 1'b1;
        for (int j = 0; j < MAX_LEN; j++) begin
          if (j < k) begin
            if (pattern[4'(len - 1 - j)] != pattern[4'(k - 1 - j)])
              ok = 1'b0;
          end
        end
        if (ok) res = k;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_detect_fsm_counter.sv
// Saturating match counter for the serial pattern detector.
// Clear takes priority over increment; the value sticks at all-ones.
module seq_sat_counter
  import seq_detect_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && count != '1) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_fsm.sv
// Parametrised serial pattern detector with KMP transition table.
// Overlap mode picks the post-match state: border length or zero.
module seq_detect_fsm
  import seq_detect_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 CNT_W   = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       valid_in,
  input  logic                       A,
  input  logic                       overlap_en,
  output logic                       Y,
  output logic [CNT_W-1:0]           match_count,
  output logic [$clog2(PAT_LEN)-1:0] progress
);

  localparam int          PW    = $clog2(PAT_LEN);
  localparam int          NS    = 1 << PW;
  localparam logic [15:0] PAT16 = 16'(PATTERN);
  localparam int          F     = border_len(PAT16, PAT_LEN);

  logic          hit_t [2*NS];
  logic [PW-1:0] nx_ov [2*NS];
  logic [PW-1:0] nx_no [2*NS];

  logic [PW-1:0] st;
  logic [PW:0]   idx;
  logic          hit;
  logic          inc;

  // Table entry {p, b}; unreachable states fall back to zero.
  for (genvar i = 0; i < NS; i++) begin : g_st
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam int N = (i < PAT_LEN) ?
        next_prefix(PAT16, PAT_LEN, i, (b == 1)) : 0;
      localparam int E = 2 * i + b;
      assign hit_t[E] = (N == PAT_LEN);
      assign nx_ov[E] = PW'((N == PAT_LEN) ? F : N);
      assign nx_no[E] = PW'((N == PAT_LEN) ? 0 : N);
    end
  end

  assign idx = {st, A};
  assign hit = hit_t[idx];
  assign inc = valid_in & hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st <= '0;
      Y  <= 1'b0;
    end else if (clear) begin
      st <= '0;
      Y  <= 1'b0;
    end else if (valid_in) begin
      Y  <= hit;
      st <= overlap_en ? nx_ov[idx] : nx_no[idx];
    end else begin
      Y  <= 1'b0;
    end
  end

  assign progress = st;

  seq_sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .inc  (inc),
    .count(match_count)
  );

endmodule

// File: doc/seq_detect_fsm.md
# seq_detect_fsm

Parametrised serial pattern detector. It samples the one-bit stream `A` on qualified cycles and recognises an arbitrary `PAT_LEN`-bit `PATTERN`, with run-time selectable overlapping or non-overlapping detection. Each detection produces a one-cycle `Y` pulse and increments a saturating match counter. It is the generalised replacement for the fixed two-flop detector FSMs in the front-end control path.

## Interface
- `PAT_LEN`, default 4: pattern length in bits, legal range 2..16.
- `PATTERN`, default 4'b1011: pattern to match. The MSB is the first bit received.
- `CNT_W`, default 8: width of the match counter.
- `clock` (in, 1): the single clock; everything is on its rising edge.
- `reset` (in, 1): asynchronous, active-high reset.
- `clear` (in, 1): synchronous clear of progress, counter and `Y`.
- `valid_in` (in, 1): `A` is sampled only when this is high.
- `A` (in, 1): serial data bit.
- `overlap_en` (in, 1): 1 selects overlapping detection, 0 selects non-overlapping.
- `Y` (out, 1): registered match pulse.
- `match_count` (out, CNT_W): saturating number of matches.
- `progress` (out, $clog2(PAT_LEN)): current matched-prefix length p.

## Operation
- **State.** p is the number of leading `PATTERN` bits currently matched, 0..PAT_LEN-1. There is one state per prefix length, so PAT_LEN states in total.
- **Transitions.** Each transition is decided by a KMP-style next-state function of (p, b), fixed at elaboration:
  - b == PATTERN[PAT_LEN-1-p] and p < PAT_LEN-1: p <= p+1.
  - b == PATTERN[0] and p == PAT_LEN-1: complete match.
    - Next p = F if `overlap_en`, where F is the longest proper border of PATTERN.
    - Next p = 0 if not `overlap_en`.
  - Mismatch: p <= the length of the longest prefix of PATTERN that is a suffix of (matched prefix ++ b). This may be nonzero.
- **No sample.** When `valid_in` = 0, p, `match_count` and `A` history hold, and `Y` <= 0.
- **Match.** On a complete match, `Y` <= 1 for exactly one cycle. `match_count` <= `match_count`+1, saturating at 2^CNT_W-1; once saturated, `Y` still pulses.
- **Overlap mode.** `overlap_en` is sampled in the same cycle as the completing bit. Changing it mid-stream affects only the next completion.
- **Priority.** `reset` > `clear` > `valid_in`. When `clear` and a completing bit coincide, `clear` wins: no `Y` pulse and no count.
- **Reset.** Values while `reset` is high: p = 0, `Y` = 0, `match_count` = 0. Reset asserted mid-pattern discards the partial match.

## Timing
- `Y`, `match_count` and `progress` are all registered. There is no combinational input-to-output path.
- Latency: `Y` is high in the cycle after the rising edge that sampled the completing bit, and `match_count` updates on that same edge.
- Throughput: one bit per cycle. Back-to-back matches are possible, e.g. all-ones pattern with `overlap_en`=1 gives `Y` high on consecutive cycles.
- `reset` deassertion is assumed synchronised upstream. The first sample can be taken on the first edge after deassertion.

## Structure
- Shared package `seq_detect_pkg` holds two items:
  - Function `next_prefix(pattern, len, p, b)` returning the next p.
  - Function `border_len(pattern, len)` returning F.
  - Both are evaluated as constants to build the transition table at elaboration.
- Sub-module `seq_sat_counter` (parameter `CNT_W`; ports `clock`, `reset`, `clear`, `inc`, `count`) provides the saturating counter.
- Top level contains the state register, the `Y` register and the counter instance.

## Test plan
- **Overlap.** PATTERN=1011, `overlap_en`=1, `valid_in`=1, stream 1,0,1,1,0,1,1 -> `Y` pulses after bits 4 and 7; `match_count`=2; `progress`=1 after bit 4.
- **Non-overlap.** Same stream with `overlap_en`=0 -> `Y` pulses only after bit 4; `match_count`=1; final `progress`=1.
- **Gaps and mismatch recovery.** Stream 1,0,1 then `valid_in`=0 for 3 cycles, then 1 -> `progress` holds at 3 during the gap and `Y` pulses once. Then stream 1,0,0 -> `progress` returns to 0 via the mismatch rule.
- **Saturation.** `CNT_W`=2, PATTERN=11, `overlap_en`=1, eight consecutive 1s -> seven `Y` pulses and `match_count` stays at 3 from the third match on.
- **Reset and clear.**
  - `reset` asserted asynchronously after 1,0,1: all outputs go to 0 immediately. A fresh 1,0,1,1 then gives exactly one match.
  - `clear` asserted in the same cycle as the completing bit: no `Y` pulse, and `match_count` reads 0.
- **Non-trivial border.** PATTERN=0101, `overlap_en`=1, stream 0,1,0,1,0,1 -> two matches, with `progress`=2 after the first.
